imem_loader: RTL

Instruction-memory writer for the RV32I single-cycle core. It accepts a framed byte stream from a host link over a valid/ready handshake and assembles little-endian 32-bit words. It writes those words sequentially into the instruction RAM write port (`data_in`/`we` side), then releases the core from hold. It is the write-side counterpart to the core's fetch path, which only reads the RAM using word address `PC[13:2]`.

---
 rtl/imem_loader_pkg.sv | 6 +
 rtl/imem_loader_if.sv | 12 +
 rtl/imem_loader_word_packer.sv | 27 ++
 rtl/imem_loader.sv | 64 ++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared loader states and instruction RAM geometry
package imem_loader_pkg;
  localparam int ADDR_W = 12;
  localparam int DEPTH = 4096;
  typedef enum logic [2:0] {S_CNT_LO, S_CNT_HI, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: host byte link plus instruction RAM write port
interface imem_loader_if;
  import imem_loader_pkg::*;
  logic [7:0] rx_data;
  logic rx_valid;
  logic rx_ready;
  logic wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0] wr_data;
  modport master(output rx_data, rx_valid, input rx_ready, wr_en, wr_addr, wr_data);
  modport slave(input rx_data, rx_valid, output rx_ready, wr_en, wr_addr, wr_data);
endinterface

// File: rtl/imem_loader_word_packer.sv
// word_packer: shifts little-endian bytes into a word and pulses valid on the 4th
module word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic        last,
  output logic        valid,
  output logic [31:0] word
);
  logic [1:0] cnt;
  assign last = cnt == 2'd3;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= '0;
      word <= '0;
      valid <= 1'b0;
    end else begin
      valid <= en && last;
      if (clr) cnt <= '0;
      else if (en) begin
        cnt <= cnt + 1'b1;
        word <= {din, word[31:8]};
      end
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a checksummed frame and writes it into instruction RAM
module imem_loader
  import imem_loader_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  imem_loader_if.slave    bus,
  output logic            core_hold,
  output logic            done,
  output logic            err,
  output logic [ADDR_W:0] words_loaded
);
  state_t state, state_n;
  logic [7:0] cnt_lo, acc;
  logic [ADDR_W:0] n_r;
  logic [15:0] n16;
  logic xfer, last, pk_en;
  assign bus.rx_ready = !start && state inside {S_CNT_LO, S_CNT_HI, S_DATA, S_CSUM};
  assign xfer = bus.rx_valid && bus.rx_ready;
  assign pk_en = xfer && state == S_DATA;
  assign n16 = {bus.rx_data, cnt_lo};
  assign core_hold = state != S_DONE;
  assign done = state == S_DONE;
  assign err = state == S_ERR;
  word_packer u_pack (
    .clk(clk), .reset(reset), .clr(start), .en(pk_en), .din(bus.rx_data),
    .last(last), .valid(bus.wr_en), .word(bus.wr_data)
  );
  always_comb begin
    state_n = state;
    if (start) state_n = S_CNT_LO;
    else if (xfer)
      case (state)
        S_CNT_LO: state_n = S_CNT_HI;
        S_CNT_HI: state_n = n16 > 16'(DEPTH) ? S_ERR : n16 == 16'd0 ? S_CSUM : S_DATA;
        S_DATA:   state_n = last && words_loaded + 1'b1 == n_r ? S_CSUM : S_DATA;
        S_CSUM:   state_n = bus.rx_data == acc ? S_DONE : S_ERR;
        default:  state_n = state;
      endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= S_CNT_LO;
      cnt_lo <= '0;
      acc <= '0;
      n_r <= '0;
      words_loaded <= '0;
      bus.wr_addr <= '0;
    end else begin
      state <= state_n;
      if (start) begin
        acc <= '0;
        words_loaded <= '0;
        bus.wr_addr <= '0;
      end else begin
        if (xfer && state != S_CSUM) acc <= acc ^ bus.rx_data;
        if (xfer && state == S_CNT_LO) cnt_lo <= bus.rx_data;
        if (xfer && state == S_CNT_HI) n_r <= n16[ADDR_W:0];
        if (pk_en && last) words_loaded <= words_loaded + 1'b1;
        if (bus.wr_en) bus.wr_addr <= bus.wr_addr + 1'b1;
      end
    end
endmodule
